countdown_bcd: RTL
==================

COUNTDOWN_BCD -- requirements
Module: countdown_bcd

Interface
REQ-001 Parameter: PRESET_DEFAULT, 16'h0300, BCD mm:ss value loaded by reset when `load` has never been asserted (03:00 egg timer).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 load  input  1  one-cycle strobe; captures `preset`.
REQ-005 preset  input  16  BCD {min_tens, min_ones, sec_tens, sec_ones}.
REQ-006 sec_clk  input  1  one-cycle-wide tick from the controller, once per second.
REQ-007 is_counting  input  1  controller level; high = run, low = pause.
REQ-008 digits  output  16  current BCD value, same packing as `preset`.
REQ-009 done  output  1  level, high while the timer is expired.
REQ-010 beep  output  1  alarm drive (see Configuration).

Function
REQ-011 The state machine SHALL have three states: IDLE (value 00:00), ARMED (value nonzero), EXPIRED (reached 00:00 by counting).
REQ-012 On `load`, `digits` SHALL take the sanitised `preset` on the next edge; the state becomes ARMED if the value is nonzero, else IDLE; `done` clears.
REQ-013 Sanitising: any digit >9 clamps to 9; sec_tens >5 clamps to 5; min_tens range 0-9.
REQ-014 A tick is `sec_clk & is_counting`; ticks SHALL be honoured only in ARMED.
REQ-015 Each tick SHALL decrement `digits` by one second, registered, with 1-cycle latency.
REQ-016 Borrow chain: sec_ones 0->9 borrows from sec_tens; sec_tens 0->5 borrows from min_ones; min_ones 0->9 borrows from min_tens.
REQ-017 A tick at 00:01 SHALL produce 00:00, state EXPIRED and `done`=1 on the same edge.
REQ-018 Ticks in IDLE or EXPIRED SHALL be ignored; no wrap below 00:00.
REQ-019 `sec_clk` while `is_counting`=0 SHALL leave `digits` unchanged (pause).
REQ-020 `done` SHALL hold high until `load` or `rst`.
REQ-021 `load` and a tick in the same cycle: `load` wins; the tick is discarded.
REQ-022 `load` while ARMED and counting SHALL restart from the new preset without an intervening tick.

Reset
REQ-023 `rst` SHALL have priority over `load` and ticks.
REQ-024 On `rst`: `digits`=PRESET_DEFAULT (sanitised); state is ARMED if nonzero, else IDLE; `done`=0; `beep`=0; the beep toggle register is 0.
REQ-025 `rst` asserted mid-count SHALL take effect on the next edge; any tick in that cycle is lost.

Configuration
REQ-026 Macro COUNTDOWN_BEEP_EN: when defined, `beep` SHALL toggle on every `sec_clk` pulse while EXPIRED, regardless of `is_counting`, and SHALL be forced 0 outside EXPIRED.
REQ-027 Without COUNTDOWN_BEEP_EN, `beep` SHALL be constant 0; the port remains present; all other behaviour is identical.

Verification
REQ-028 rst=1 for 1 cycle, PRESET_DEFAULT=16'h0300 -> digits=16'h0300, done=0, beep=0.
REQ-029 load with preset=16'h0100, is_counting=1, then 1 tick -> digits=16'h0059; after 59 more ticks -> digits=16'h0000, done=1; one further tick -> digits stays 16'h0000.
REQ-030 preset=16'h0005, is_counting=0, 3 sec_clk pulses -> digits stays 16'h0005; set is_counting=1, 2 ticks -> 16'h0003.
REQ-031 preset=16'hFA7C, load -> digits=16'h9959; load and tick in the same cycle with preset=16'h0010 -> digits=16'h0010.
REQ-032 In EXPIRED with COUNTDOWN_BEEP_EN defined, 4 sec_clk pulses -> beep toggles 4 times and ends at 0; load -> beep=0, done=0; rebuild without the macro -> beep always 0.
REQ-033 While counting at 16'h0142, assert rst for 1 cycle with a tick in the same cycle -> digits=16'h0300, done=0.

Source files
------------

// File: rtl/countdown_bcd.sv
// BCD mm:ss countdown timer with IDLE/ARMED/EXPIRED states.
// Define COUNTDOWN_BEEP_EN to drive a toggling beep while expired.
module countdown_bcd #(
   parameter logic [15:0] PRESET_DEFAULT = 16'h0300
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] preset,
   input  logic        sec_clk,
   input  logic        is_counting,
   output logic [15:0] digits,
   output logic        done,
   output logic        beep
);

   typedef enum logic [1:0] {IDLE, ARMED, EXPIRED} state_t;

   function automatic logic [15:0] sanitise(input logic [15:0] v);
      logic [3:0] mt, mo, st, so;
      mt = (v[15:12] > 4'd9) ? 4'd9 : v[15:12];
      mo = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
      st = (v[7:4]   > 4'd5) ? 4'd5 : v[7:4];
      so = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
      return {mt, mo, st, so};
   endfunction

   // Only called with a nonzero value, so min_tens never underflows.
   function automatic logic [15:0] dec_sec(input logic [15:0] v);
      logic [3:0] mt, mo, st, so;
      {mt, mo, st, so} = v;
      if (so != 4'd0) begin
         so = so - 4'd1;
      end else begin
         so = 4'd9;
         if (st != 4'd0) begin
            st = st - 4'd1;
         end else begin
            st = 4'd5;
            if (mo != 4'd0) begin
               mo = mo - 4'd1;
            end else begin
               mo = 4'd9;
               mt = mt - 4'd1;
            end
         end
      end
      return {mt, mo, st, so};
   endfunction

   localparam logic [15:0] RST_VAL = sanitise(PRESET_DEFAULT);

   state_t      state_q, state_d;
   logic [15:0] digits_q, digits_d;
   logic        done_q, done_d;
   logic        beep_q, beep_d;
   logic [15:0] load_val;
   logic        tick;

   always_comb begin
      tick     = sec_clk & is_counting;
      load_val = sanitise(preset);
      state_d  = state_q;
      digits_d = digits_q;
      done_d   = done_q;
      if (load) begin
         digits_d = load_val;
         state_d  = (load_val != 16'h0000) ? ARMED : IDLE;
         done_d   = 1'b0;
      end else if (tick && state_q == ARMED) begin
         digits_d = dec_sec(digits_q);
         if (digits_d == 16'h0000) begin
            state_d = EXPIRED;
            done_d  = 1'b1;
         end
      end
   end

   always_comb begin
      beep_d = 1'b0;
`ifdef COUNTDOWN_BEEP_EN
      if (state_q == EXPIRED && state_d == EXPIRED) begin
         beep_d = sec_clk ? ~beep_q : beep_q;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= (RST_VAL != 16'h0000) ? ARMED : IDLE;
         digits_q <= RST_VAL;
         done_q   <= 1'b0;
         beep_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         digits_q <= digits_d;
         done_q   <= done_d;
         beep_q   <= beep_d;
      end
   end

   assign digits = digits_q;
   assign done   = done_q;
   assign beep   = beep_q;

endmodule
